// File: rtl/float_lzc_arbiter.sv
// Round-robin shared leading-zero counter and normalizing shifter with a one-entry
// valid/ready result register. Define FLOAT_LZC_ARB_STATS_EN to add the stall_cnt output.
module float_lzc_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 24,
    parameter int LZC_WIDTH  = 5,
    parameter int ID_WIDTH   = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [ID_WIDTH-1:0]             out_id,
    output logic [LZC_WIDTH-1:0]            out_lzc,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_zero
`ifdef FLOAT_LZC_ARB_STATS_EN
    ,
    output logic [15:0]                     stall_cnt
`endif
);

    // Handshake: a transfer occurs on a rising edge where valid && ready are both high,
    // on each requester port and on the output port; valid never waits on ready.

    logic [ID_WIDTH-1:0]   r_ptr;
    logic                  r_out_valid;
    logic [ID_WIDTH-1:0]   r_out_id;
    logic [LZC_WIDTH-1:0]  r_out_lzc;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_zero;

    logic [ID_WIDTH-1:0]   w_winner;
    logic                  w_any;
    logic                  w_can_load;
    logic                  w_grant;
    logic [DATA_WIDTH-1:0] w_sel;
    logic [LZC_WIDTH-1:0]  w_lzc;
    logic [DATA_WIDTH-1:0] w_norm;
    logic                  w_zero;
    logic [ID_WIDTH-1:0]   w_ptr_next;

    function automatic logic [ID_WIDTH-1:0] rr_index(input logic [ID_WIDTH-1:0] base,
                                                      input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_WIDTH'(s);
    endfunction

    // Scan from the farthest offset back to ptr so the last hit is the first in rotation.
    always_comb begin
        w_winner = '0;
        w_any    = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[rr_index(r_ptr, k)]) begin
                w_winner = rr_index(r_ptr, k);
                w_any    = 1'b1;
            end
        end
    end

    assign w_can_load = !r_out_valid || out_ready;
    assign w_grant    = w_any && w_can_load && rst_n;

    always_comb begin
        req_ready = '0;
        if (w_grant) req_ready[w_winner] = 1'b1;
    end

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == ID_WIDTH'(i)) w_sel = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Highest set bit wins because later iterations overwrite earlier ones.
    always_comb begin
        w_lzc = LZC_WIDTH'(DATA_WIDTH);
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (w_sel[i]) w_lzc = LZC_WIDTH'(DATA_WIDTH - 1 - i);
        end
    end

    assign w_norm     = w_sel << w_lzc;
    assign w_zero     = (w_sel == '0);
    assign w_ptr_next = (w_winner == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_id    <= '0;
            r_out_lzc   <= '0;
            r_out_data  <= '0;
            r_out_zero  <= 1'b0;
        end else if (w_grant) begin
            r_out_valid <= 1'b1;
            r_out_id    <= w_winner;
            r_out_lzc   <= w_lzc;
            r_out_data  <= w_norm;
            r_out_zero  <= w_zero;
            r_ptr       <= w_ptr_next;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_id    = r_out_id;
    assign out_lzc   = r_out_lzc;
    assign out_data  = r_out_data;
    assign out_zero  = r_out_zero;

`ifdef FLOAT_LZC_ARB_STATS_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (r_out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_float_lzc_arbiter.sv
// Scoreboard bench for float_lzc_arbiter: a rotation/arithmetic reference model predicts
// grants and results; a monitor pops and compares whenever a result is consumed.
module tb_float_lzc_arbiter;

  localparam int N  = 4;
  localparam int DW = 24;
  localparam int LW = 5;
  localparam int IW = 2;
  localparam int W  = IW + LW + DW + 1;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_data;
  logic            out_valid;
  logic            out_ready;
  logic [IW-1:0]   out_id;
  logic [LW-1:0]   out_lzc;
  logic [DW-1:0]   out_data;
  logic            out_zero;
`ifdef FLOAT_LZC_ARB_STATS_EN
  logic [15:0]     stall_cnt;
`endif

  float_lzc_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .LZC_WIDTH(LW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .out_lzc(out_lzc), .out_data(out_data), .out_zero(out_zero)
`ifdef FLOAT_LZC_ARB_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];
  logic [N-1:0] grant_mask;
  int           refill_pct;
  bit           rand_ready;

  int           m_ptr;
  bit           m_valid;
  int           m_stall;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: count zeros down from the MSB, then shift
  function automatic logic [W-1:0] ref_result(input int id, input logic [DW-1:0] d);
    int lz;
    logic [DW-1:0] sh;
    lz = 0;
    while (lz < DW && d[DW-1-lz] == 1'b0) lz++;
    sh = d << lz;
    return {IW'(id), LW'(lz), sh, (d == 0) ? 1'b1 : 1'b0};
  endfunction

  function automatic logic [DW-1:0] rand_mant();
    logic [DW-1:0] v;
    int sel;
    sel = $urandom_range(0, 9);
    v = DW'($urandom);
    if (sel == 0) v = '0;
    else if (sel == 1) v[DW-1] = 1'b1;
    else v = v >> $urandom_range(0, DW - 1);
    return v;
  endfunction

  // reference model: predicts req_ready, pushes expected results
  always @(negedge clk) begin
    logic [N-1:0] exp_ready;
    int winner;
    bit can_load;
    if (!rst_n) begin
      m_ptr = 0; m_valid = 0; m_stall = 0;
      grant_mask = '0;
      exp_q.delete();
    end else begin
      check("out_valid", 64'(out_valid), 64'(m_valid));
`ifdef FLOAT_LZC_ARB_STATS_EN
      check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
      can_load = !m_valid || out_ready;
      winner = -1;
      for (int k = 0; k < N; k++) begin
        if (winner < 0 && req_valid[(m_ptr + k) % N]) winner = (m_ptr + k) % N;
      end
      exp_ready = '0;
      if (winner >= 0 && can_load) exp_ready[winner] = 1'b1;
      check("req_ready", 64'(req_ready), 64'(exp_ready));
      grant_mask = exp_ready;
      if (m_valid && !out_ready && m_stall < 65535) m_stall++;
      if (exp_ready != 0) begin
        exp_q.push_back(ref_result(winner, req_data[winner*DW +: DW]));
        m_ptr = (winner + 1) % N;
        m_valid = 1;
      end else if (out_ready) begin
        m_valid = 0;
      end
    end
  end

  // monitor: pops on every consumed result, checks hold during stalls
  logic [W-1:0] snap;
  bit           prev_hold = 0;
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] e;
    got = {out_id, out_lzc, out_data, out_zero};
    if (!rst_n) begin
      prev_hold = 0;
    end else begin
      if (prev_hold) check("stall_hold", 64'(got), 64'(snap));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL result: got %0h expected nothing at %0t", got, $time);
        end else begin
          e = exp_q.pop_front();
          check("result", 64'(got), 64'(e));
        end
      end
      prev_hold = out_valid && !out_ready;
      snap = got;
    end
  end

  // driver tasks
  task automatic set_req(input int i, input logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (grant_mask[i]) req_valid[i] = 1'b0;
      if (!req_valid[i] && $urandom_range(1, 100) <= refill_pct) set_req(i, rand_mant());
    end
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  int fair_exp[3] = '{3, 0, 3};
  int s0;

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; out_ready = 1'b1;
    refill_pct = 0; rand_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_fields", 64'({out_id, out_lzc, out_data, out_zero}), 0);
    check("rst_req_ready", 64'(req_ready), 0);
    rst_n = 1'b1;

    // single request
    set_req(2, 24'h000F00);
    cycle();
    check("single_id", 64'(out_id), 2);
    check("single_lzc", 64'(out_lzc), 12);
    check("single_data", 64'(out_data), 64'h00F0_0000);
    check("single_zero", 64'(out_zero), 0);

    // zero and MSB-set mantissas
    set_req(0, 24'h000000);
    cycle();
    check("zero_lzc", 64'(out_lzc), 24);
    check("zero_data", 64'(out_data), 0);
    check("zero_flag", 64'(out_zero), 1);
    set_req(1, 24'h800000);
    cycle();
    check("msb_lzc", 64'(out_lzc), 0);
    check("msb_data", 64'(out_data), 64'h0080_0000);

    // fairness: bring ptr to 1, then hold requesters 0 and 3
    set_req(0, rand_mant());
    cycle();
    set_req(0, rand_mant());
    set_req(3, rand_mant());
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("fair_id", 64'(out_id), 64'(fair_exp[k]));
      if (!req_valid[0]) set_req(0, rand_mant());
      if (!req_valid[3]) set_req(3, rand_mant());
    end
    req_valid = '0;
    cycle();

    // round-robin with all requesters kept busy
    refill_pct = 100;
    repeat (12) cycle();

    // backpressure for 5 edges, then release
    out_ready = 1'b0;
    s0 = 0;
`ifdef FLOAT_LZC_ARB_STATS_EN
    s0 = int'(stall_cnt);
`endif
    repeat (5) cycle();
`ifdef FLOAT_LZC_ARB_STATS_EN
    check("stall_delta", 64'(int'(stall_cnt) - s0), 5);
`endif
    out_ready = 1'b1;
    repeat (4) cycle();

    // random traffic
    refill_pct = 60;
    rand_ready = 1;
    repeat (400) cycle();

    // reset mid-stream with a full register
    rand_ready = 0;
    out_ready = 1'b0;
    refill_pct = 100;
    repeat (2) cycle();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 0);
    check("midrst_req_ready", 64'(req_ready), 0);
    check("midrst_fields", 64'({out_id, out_lzc, out_data, out_zero}), 0);
    refill_pct = 0;
    req_valid = '0;
    repeat (2) cycle();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, rand_mant());
    cycle();
    check("post_rst_id", 64'(out_id), 0);

    // drain
    req_valid = '0;
    repeat (4) cycle();
    check("drain_empty", 64'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
